// File: rtl/dift_tag_check.sv
// Tag-check unit for dynamic information flow tracking.
// Looks at the EX-stage instruction and its operand and fetch tags.
// When an enabled check sees a tainted tag, it raises a tag-violation
// exception request. The request holds until the controller acks it.
// It also keeps a saturating violation counter and a sticky overflow flag.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid_i             EX instruction valid and not stalled
//   opclass_i, jalr_i   instruction class and JALR flag
//   operand_a/b_tag_i   rs1/rs2 tags
//   instr_tag_i         tag of the fetched instruction word
//   pc_i                EX instruction PC
//   check_en_i          check enables {EXEC,JALR,STOR,LOAD,BRAN}
//   exc_ack_i           controller took the exception
//   clr_i               clear counter and overflow flag
//   exc_req_o           exception request (high while pending)
//   viol_cause_o/pc_o   captured cause code and PC
//   viol_cnt_o          saturating violation count
//   viol_ovf_o          sticky: violation while one was pending

package dift_pkg;
  localparam int unsigned DIFT_TAG_W = 2;
  typedef logic [DIFT_TAG_W-1:0] dift_tag_t;

  typedef enum logic [2:0] {
    DIFT_OP_NONE = 3'd0,
    DIFT_OP_ALU  = 3'd1,
    DIFT_OP_LOAD = 3'd2,
    DIFT_OP_STOR = 3'd3,
    DIFT_OP_BRAN = 3'd4,
    DIFT_OP_JUMP = 3'd5
  } dift_prop_opclass_t;

  localparam logic [2:0] CAUSE_NONE = 3'd0;
  localparam logic [2:0] CAUSE_STOR = 3'd1;
  localparam logic [2:0] CAUSE_LOAD = 3'd2;
  localparam logic [2:0] CAUSE_BRAN = 3'd3;
  localparam logic [2:0] CAUSE_JALR = 3'd4;
  localparam logic [2:0] CAUSE_EXEC = 3'd5;
endpackage

module dift_tag_check
  import dift_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  dift_prop_opclass_t   opclass_i,
  input  logic                 jalr_i,
  input  dift_tag_t            operand_a_tag_i,
  input  dift_tag_t            operand_b_tag_i,
  input  dift_tag_t            instr_tag_i,
  input  logic [31:0]          pc_i,
  input  logic [4:0]           check_en_i,
  input  logic                 exc_ack_i,
  input  logic                 clr_i,
  output logic                 exc_req_o,
  output logic [2:0]           viol_cause_o,
  output logic [31:0]          viol_pc_o,
  output logic [CNT_WIDTH-1:0] viol_cnt_o,
  output logic                 viol_ovf_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_e               state_q, state_d;
  logic [2:0]           cause_q, cause_d;
  logic [31:0]          pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic                 a_taint_c, b_taint_c, i_taint_c;
  logic [2:0]           cause_c;
  logic                 viol_c;

  // Taint is the OR of all tag bits
  assign a_taint_c = |operand_a_tag_i;
  assign b_taint_c = |operand_b_tag_i;
  assign i_taint_c = |instr_tag_i;

  // Prioritised cause: EXEC > JALR > BRAN > LOAD > STOR
  always_comb begin
    cause_c = CAUSE_NONE;
    if (valid_i) begin
      if (check_en_i[4] && i_taint_c) begin
        cause_c = CAUSE_EXEC;
      end else if (check_en_i[3] && jalr_i && a_taint_c) begin
        cause_c = CAUSE_JALR;
      end else if (check_en_i[0] && (opclass_i == DIFT_OP_BRAN) && (a_taint_c || b_taint_c)) begin
        cause_c = CAUSE_BRAN;
      end else if (check_en_i[1] && (opclass_i == DIFT_OP_LOAD) && a_taint_c) begin
        cause_c = CAUSE_LOAD;
      end else if (check_en_i[2] && (opclass_i == DIFT_OP_STOR) && a_taint_c) begin
        cause_c = CAUSE_STOR;
      end
    end
  end

  assign viol_c = (cause_c != CAUSE_NONE);

  // Next-state: request FSM, capture registers, counter and overflow
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (viol_c) begin
          state_d = S_REQ;
          cause_d = cause_c;
          pc_d    = pc_i;
        end
      end
      S_REQ: begin
        if (exc_ack_i) begin
          // An ack cycle with a new violation rolls straight into the next request
          if (viol_c) begin
            cause_d = cause_c;
            pc_d    = pc_i;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clear wins over a same-cycle violation for counter and overflow
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (viol_c) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      if ((state_q == S_REQ) && !exc_ack_i) begin
        ovf_d = 1'b1;
      end
    end
  end

  // State and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cause_q <= CAUSE_NONE;
      pc_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign exc_req_o    = (state_q == S_REQ);
  assign viol_cause_o = cause_q;
  assign viol_pc_o    = pc_q;
  assign viol_cnt_o   = cnt_q;
  assign viol_ovf_o   = ovf_q;

endmodule

// File: tb/tb_dift_tag_check.sv
// Bench for dift_tag_check: directed scenarios plus random traffic.
// A second instance with CNT_WIDTH=2 shares the inputs and covers counter saturation.
module tb_dift_tag_check;
  import dift_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid_i;
  dift_prop_opclass_t opclass_i;
  logic               jalr_i;
  dift_tag_t          a_tag, b_tag, i_tag;
  logic [31:0]        pc_i;
  logic [4:0]         check_en_i;
  logic               exc_ack_i;
  logic               clr_i;

  logic               exc_req, ovf, exc_req2, ovf2;
  logic [2:0]         cause, cause2;
  logic [31:0]        vpc, vpc2;
  logic [15:0]        cnt;
  logic [1:0]         cnt2;

  int checks = 0;
  int failures = 0;

  // Reference state
  bit          m_pend;
  logic [2:0]  m_cause;
  logic [31:0] m_pc;
  int          m_cnt, m_cnt2;
  bit          m_ovf;

  always #5 clk = ~clk;

  dift_tag_check #(.CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .opclass_i(opclass_i), .jalr_i(jalr_i),
    .operand_a_tag_i(a_tag), .operand_b_tag_i(b_tag), .instr_tag_i(i_tag), .pc_i(pc_i),
    .check_en_i(check_en_i), .exc_ack_i(exc_ack_i), .clr_i(clr_i),
    .exc_req_o(exc_req), .viol_cause_o(cause), .viol_pc_o(vpc), .viol_cnt_o(cnt), .viol_ovf_o(ovf)
  );

  dift_tag_check #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .opclass_i(opclass_i), .jalr_i(jalr_i),
    .operand_a_tag_i(a_tag), .operand_b_tag_i(b_tag), .instr_tag_i(i_tag), .pc_i(pc_i),
    .check_en_i(check_en_i), .exc_ack_i(exc_ack_i), .clr_i(clr_i),
    .exc_req_o(exc_req2), .viol_cause_o(cause2), .viol_pc_o(vpc2), .viol_cnt_o(cnt2), .viol_ovf_o(ovf2)
  );

  // Cause from the rule list, highest priority first
  function automatic logic [2:0] ref_cause();
    if (!valid_i) return 3'd0;
    if (check_en_i[4] && (i_tag != 0)) return 3'd5;
    if (check_en_i[3] && jalr_i && (a_tag != 0)) return 3'd4;
    if (check_en_i[0] && opclass_i == DIFT_OP_BRAN && (a_tag != 0 || b_tag != 0)) return 3'd3;
    if (check_en_i[1] && opclass_i == DIFT_OP_LOAD && (a_tag != 0)) return 3'd2;
    if (check_en_i[2] && opclass_i == DIFT_OP_STOR && (a_tag != 0)) return 3'd1;
    return 3'd0;
  endfunction

  // Advance one clock; the model consumes the inputs sampled at that edge
  task automatic tick();
    logic [2:0] c;
    @(posedge clk);
    c = ref_cause();
    if (rst) begin
      m_pend = 0; m_cause = 0; m_pc = 0; m_cnt = 0; m_cnt2 = 0; m_ovf = 0;
    end else begin
      if (clr_i) begin
        m_cnt = 0; m_cnt2 = 0; m_ovf = 0;
      end else if (c != 0) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
        if (m_pend && !exc_ack_i) m_ovf = 1;
      end
      if (!m_pend) begin
        if (c != 0) begin m_pend = 1; m_cause = c; m_pc = pc_i; end
      end else if (exc_ack_i) begin
        if (c != 0) begin m_cause = c; m_pc = pc_i; end
        else m_pend = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; valid_i = 0; opclass_i = DIFT_OP_NONE; jalr_i = 0;
    a_tag = 0; b_tag = 0; i_tag = 0; pc_i = 0; check_en_i = 0; exc_ack_i = 0; clr_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; valid_i = 1; check_en_i = 5'h1f; i_tag = 2'b11; clr_i = 1; exc_ack_i = 1;
    tick();
    tick();
    idle_inputs();
    checks++;
    if (exc_req !== 1'b0 || cause !== 3'd0 || vpc !== 32'd0 || cnt !== 16'd0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset: got req=%b cause=%0d pc=%h cnt=%0d ovf=%b, want all zero", exc_req, cause, vpc, cnt, ovf);
    end
  endtask

  task automatic test_load();
    do_reset();
    valid_i = 1; opclass_i = DIFT_OP_LOAD; check_en_i = 5'b00010; a_tag = 2'b01; pc_i = 32'h100;
    tick();
    idle_inputs();
    checks++;
    if (exc_req !== 1'b1 || cause !== 3'd2 || vpc !== 32'h100 || cnt !== 16'd1) begin
      failures++;
      $display("FAIL load: got req=%b cause=%0d pc=%h cnt=%0d, want 1 2 100 1", exc_req, cause, vpc, cnt);
    end
    exc_ack_i = 1;
    tick();
    idle_inputs();
    checks++;
    if (exc_req !== 1'b0) begin
      failures++;
      $display("FAIL load_ack: got req=%b want 0", exc_req);
    end
  endtask

  task automatic test_priority();
    do_reset();
    valid_i = 1; opclass_i = DIFT_OP_BRAN; check_en_i = 5'b11111; i_tag = 2'b10; b_tag = 2'b01;
    pc_i = 32'h200;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (exc_req !== 1'b1 || cause !== 3'd5 || vpc !== 32'h200) begin
        failures++;
        $display("FAIL priority_hold[%0d]: got req=%b cause=%0d pc=%h, want 1 5 200", i, exc_req, cause, vpc);
      end
      tick();
    end
    exc_ack_i = 1;
    tick();
    idle_inputs();
    checks++;
    if (exc_req !== 1'b0 || cnt !== 16'd1) begin
      failures++;
      $display("FAIL priority_ack: got req=%b cnt=%0d, want 0 1", exc_req, cnt);
    end
    // JALR outranks BRAN when EXEC is quiet
    valid_i = 1; opclass_i = DIFT_OP_BRAN; jalr_i = 1; check_en_i = 5'b11111; a_tag = 2'b11; pc_i = 32'h240;
    tick();
    idle_inputs();
    checks++;
    if (cause !== 3'd4 || vpc !== 32'h240) begin
      failures++;
      $display("FAIL priority_jalr: got cause=%0d pc=%h, want 4 240", cause, vpc);
    end
  endtask

  task automatic test_overflow_clr();
    do_reset();
    valid_i = 1; opclass_i = DIFT_OP_LOAD; check_en_i = 5'b00110; a_tag = 2'b01; pc_i = 32'h100;
    tick();
    opclass_i = DIFT_OP_STOR; pc_i = 32'h300;
    tick();
    idle_inputs();
    checks++;
    if (exc_req !== 1'b1 || cause !== 3'd2 || vpc !== 32'h100 || ovf !== 1'b1 || cnt !== 16'd2) begin
      failures++;
      $display("FAIL overflow: got req=%b cause=%0d pc=%h ovf=%b cnt=%0d, want 1 2 100 1 2", exc_req, cause, vpc, ovf, cnt);
    end
    // Clear together with a violation: the violation is neither counted nor flagged
    clr_i = 1; valid_i = 1; opclass_i = DIFT_OP_STOR; check_en_i = 5'b00100; a_tag = 2'b10; pc_i = 32'h310;
    tick();
    idle_inputs();
    checks++;
    if (cnt !== 16'd0 || ovf !== 1'b0 || exc_req !== 1'b1 || cause !== 3'd2 || vpc !== 32'h100) begin
      failures++;
      $display("FAIL clr: got cnt=%0d ovf=%b req=%b cause=%0d pc=%h, want 0 0 1 2 100", cnt, ovf, exc_req, cause, vpc);
    end
  endtask

  task automatic test_ack_new();
    exc_ack_i = 1; valid_i = 1; opclass_i = DIFT_OP_STOR; check_en_i = 5'b00100; a_tag = 2'b01;
    pc_i = 32'h400;
    tick();
    idle_inputs();
    checks++;
    if (exc_req !== 1'b1 || cause !== 3'd1 || vpc !== 32'h400 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL ack_new: got req=%b cause=%0d pc=%h ovf=%b, want 1 1 400 0", exc_req, cause, vpc, ovf);
    end
    exc_ack_i = 1;
    tick();
    idle_inputs();
    checks++;
    if (exc_req !== 1'b0 || cause !== 3'd1) begin
      failures++;
      $display("FAIL ack_new_idle: got req=%b cause=%0d, want 0 1", exc_req, cause);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      valid_i = 1; opclass_i = DIFT_OP_LOAD; check_en_i = 5'b00010; a_tag = 2'b11;
      exc_ack_i = 1; pc_i = 32'(i * 4);
      tick();
      checks++;
      if (int'(cnt2) !== ((i < 3) ? i : 3) || int'(cnt) !== i) begin
        failures++;
        $display("FAIL saturate[%0d]: got cnt2=%0d cnt=%0d, want %0d %0d", i, cnt2, cnt, (i < 3) ? i : 3, i);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_in_req();
    do_reset();
    valid_i = 1; opclass_i = DIFT_OP_LOAD; check_en_i = 5'b00010; a_tag = 2'b01; pc_i = 32'h500;
    tick();
    rst = 1; clr_i = 1; exc_ack_i = 1; check_en_i = 5'b11111; i_tag = 2'b01;
    tick();
    idle_inputs();
    checks++;
    if (exc_req !== 1'b0 || cause !== 3'd0 || vpc !== 32'd0 || cnt !== 16'd0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_req: got req=%b cause=%0d pc=%h cnt=%0d ovf=%b, want all zero", exc_req, cause, vpc, cnt, ovf);
    end
    // Tainted everything but not valid: nothing happens
    check_en_i = 5'b11111; opclass_i = DIFT_OP_BRAN; jalr_i = 1; a_tag = 2'b11; b_tag = 2'b11; i_tag = 2'b11;
    for (int i = 0; i < 4; i++) begin
      pc_i = $urandom;
      tick();
    end
    idle_inputs();
    checks++;
    if (exc_req !== 1'b0 || cnt !== 16'd0) begin
      failures++;
      $display("FAIL valid_low: got req=%b cnt=%0d, want 0 0", exc_req, cnt);
    end
  endtask

  task automatic test_disabled();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      valid_i = 1; check_en_i = 0; jalr_i = 1'($urandom);
      opclass_i = dift_prop_opclass_t'(3'($urandom_range(0, 5)));
      a_tag = 2'($urandom); b_tag = 2'($urandom); i_tag = 2'($urandom); pc_i = $urandom;
      tick();
    end
    idle_inputs();
    checks++;
    if (exc_req !== 1'b0 || cnt !== 16'd0) begin
      failures++;
      $display("FAIL disabled: got req=%b cnt=%0d, want 0 0", exc_req, cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      clr_i      = ($urandom_range(0, 19) == 0);
      exc_ack_i  = ($urandom_range(0, 2) == 0);
      valid_i    = ($urandom_range(0, 3) != 0);
      jalr_i     = ($urandom_range(0, 3) == 0);
      opclass_i  = dift_prop_opclass_t'(3'($urandom_range(0, 5)));
      check_en_i = 5'($urandom);
      a_tag      = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
      b_tag      = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
      i_tag      = ($urandom_range(0, 3) != 0) ? 2'b00 : 2'($urandom);
      pc_i       = $urandom;
      tick();
      checks++;
      if (exc_req !== 1'(m_pend) || cause !== m_cause || vpc !== m_pc ||
          int'(cnt) !== m_cnt || int'(cnt2) !== m_cnt2 || ovf !== 1'(m_ovf)) begin
        failures++;
        $display("FAIL random[%0d]: got req=%b cause=%0d pc=%h cnt=%0d cnt2=%0d ovf=%b, want %b %0d %h %0d %0d %b",
                 i, exc_req, cause, vpc, cnt, cnt2, ovf, m_pend, m_cause, m_pc, m_cnt, m_cnt2, m_ovf);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_pend = 0; m_cause = 0; m_pc = 0; m_cnt = 0; m_cnt2 = 0; m_ovf = 0;
    test_reset();
    test_load();
    test_priority();
    test_overflow_clr();
    test_ack_new();
    test_saturate();
    test_reset_in_req();
    test_disabled();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
